// File: rtl/multiplier_iter_if.sv
// Operand/result stream bundle for multiplier_iter: request side (A, B, is_signed)
// and result side (ans), each with its own valid/ready pair.
interface multiplier_iter_if #(
  parameter int WIDTH = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   ans;

  modport master (
    output in_valid, A, B, is_signed, out_ready,
    input  in_ready, out_valid, ans
  );

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
    output in_ready, out_valid, ans
  );
endinterface

// File: rtl/multiplier_iter.sv
// Iterative shift-add WIDTHxWIDTH multiplier (signed/unsigned), one adder reused WIDTH cycles.
// ans valid WIDTH cycles after accept and held until out_ready; operands accepted only when idle.
module multiplier_iter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  multiplier_iter_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     acc_hi;
  logic                 neg;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   ans_q;

  logic                 accept;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   ans_nxt;

  assign accept = bus.in_valid && bus.in_ready;

  // Magnitudes as WIDTH-bit unsigned: the most negative value maps to 2^(WIDTH-1).
  assign a_abs = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_abs = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  assign addend  = mplier[0] ? mcand : '0;
  assign sum     = {1'b0, acc_hi} + {1'b0, addend};
  // Product as it stands after this cycle's shift; only used on the last step.
  assign prod    = {sum, mplier[WIDTH-1:1]};
  assign ans_nxt = neg ? -prod : prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && !rst;
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      ans_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_abs;
            mplier <= b_abs;
            acc_hi <= '0;
            neg    <= bus.is_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            cnt    <= '0;
          end
        end
        CALC: begin
          acc_hi <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            ans_q <= ans_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ans = ans_q;

endmodule

// File: tb/tb_multiplier_iter.sv
// Directed checks on a WIDTH=6 multiplier plus randomized runs against a reference
// product on WIDTH=8 and WIDTH=16 instances.
module tb_multiplier_iter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multiplier_iter_if #(.WIDTH(6))  bus6 ();
  multiplier_iter_if #(.WIDTH(8))  bus8 ();
  multiplier_iter_if #(.WIDTH(16)) bus16 ();

  multiplier_iter #(.WIDTH(6))  dut6  (.clk(clk), .rst(rst), .bus(bus6));
  multiplier_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  multiplier_iter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one W=6 request; lat = cycles from the accept edge to out_valid, -1 on timeout.
  // With junk=1 in_valid stays high with other operands while the block is busy.
  task automatic do_op6(input logic [5:0] a, input logic [5:0] b, input logic s,
                        input bit junk, output int lat);
    int t;
    @(negedge clk);
    bus6.A = a; bus6.B = b; bus6.is_signed = s; bus6.in_valid = 1'b1;
    t = 0;
    while (!bus6.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    bus6.A = ~a; bus6.B = ~b; bus6.is_signed = ~s; bus6.in_valid = junk;
    lat = 0;
    while (!bus6.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus6.out_valid) lat = -1;
    bus6.in_valid = 1'b0;
  endtask

  task automatic pop6();
    bus6.out_ready = 1'b1;
    @(negedge clk);
    bus6.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus6.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus6.in_ready); end
    checks++; if (bus6.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus6.out_valid); end
    checks++; if (bus6.ans !== 12'h000) begin errors++; $display("FAIL reset_ans got %h want 000", bus6.ans); end
    rst = 1'b0;
    #1;
    checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus6.in_ready); end
  endtask

  task automatic test_directed(input string name, input logic [5:0] a, input logic [5:0] b,
                               input logic s, input logic [11:0] want);
    int lat;
    do_op6(a, b, s, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL %s_latency got %0d want 6", name, lat); end
    checks++; if (bus6.ans !== want) begin errors++; $display("FAIL %s_ans got %h want %h", name, bus6.ans, want); end
    pop6();
    checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready_after got %b want 1", name, bus6.in_ready); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op6(6'd7, 6'd9, 1'b0, 1'b0, lat);
    checks++; if (bus6.ans !== 12'h03F) begin errors++; $display("FAIL bp_ans got %h want 03F", bus6.ans); end
    bus6.A = 6'd1; bus6.B = 6'd1; bus6.is_signed = 1'b0; bus6.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus6.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", k, bus6.out_valid); end
      checks++; if (bus6.ans !== 12'h03F) begin errors++; $display("FAIL bp_hold_ans cycle %0d got %h want 03F", k, bus6.ans); end
      checks++; if (bus6.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", k, bus6.in_ready); end
    end
    bus6.in_valid = 1'b0;
    pop6();
    checks++; if (bus6.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus6.out_valid); end
    checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", bus6.in_ready); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    do_op6(6'd10, 6'd11, 1'b0, 1'b1, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL busy_latency got %0d want 6", lat); end
    checks++; if (bus6.ans !== 12'h06E) begin errors++; $display("FAIL busy_ans got %h want 06E", bus6.ans); end
    pop6();
  endtask

  task automatic test_back_to_back();
    int idx[2];
    int n;
    n = 0;
    @(negedge clk);
    bus6.A = 6'd5; bus6.B = 6'd6; bus6.is_signed = 1'b0; bus6.in_valid = 1'b1; bus6.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus6.out_valid && n < 2) begin
        idx[n] = c;
        n++;
        checks++; if (bus6.ans !== 12'h01E) begin errors++; $display("FAIL b2b_ans got %h want 01E", bus6.ans); end
      end
    end
    bus6.in_valid = 1'b0;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_results got %0d want 2", n); end
    else begin
      checks++; if (idx[1] - idx[0] !== 8) begin errors++; $display("FAIL b2b_interval got %0d want 8", idx[1] - idx[0]); end
    end
    repeat (12) @(negedge clk);
    bus6.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus6.A = 6'd20; bus6.B = 6'd3; bus6.is_signed = 1'b0; bus6.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus6.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus6.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", bus6.out_valid); end
    checks++; if (bus6.ans !== 12'h000) begin errors++; $display("FAIL midrst_ans got %h want 000", bus6.ans); end
    checks++; if (bus6.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus6.in_ready); end
    do_op6(6'd12, 6'h3D, 1'b1, 1'b0, lat);
    checks++; if (lat !== 6) begin errors++; $display("FAIL midrst_new_latency got %0d want 6", lat); end
    checks++; if (bus6.ans !== 12'hFDC) begin errors++; $display("FAIL midrst_new_ans got %h want FDC", bus6.ans); end
    pop6();
  endtask

  task automatic set_in(input int w, input longint a, input longint b, input logic s, input logic v);
    if (w == 8) begin
      bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.is_signed = s; bus8.in_valid = v;
    end else begin
      bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.is_signed = s; bus16.in_valid = v;
    end
  endtask

  task automatic set_out_ready(input int w, input logic r);
    if (w == 8) bus8.out_ready = r;
    else bus16.out_ready = r;
  endtask

  function automatic logic get_in_ready(input int w);
    return (w == 8) ? bus8.in_ready : bus16.in_ready;
  endfunction

  function automatic logic get_out_valid(input int w);
    return (w == 8) ? bus8.out_valid : bus16.out_valid;
  endfunction

  function automatic longint get_ans(input int w);
    return (w == 8) ? longint'(bus8.ans) : longint'(bus16.ans);
  endfunction

  task automatic test_random(input int w, input int n);
    longint mask, a, b, av, bv, want, got;
    logic   s;
    int     t, lat;
    mask = (longint'(1) << w) - 1;
    for (int i = 0; i < n; i++) begin
      a = longint'($urandom) & mask;
      b = longint'($urandom) & mask;
      s = 1'($urandom_range(0, 1));
      av = a; bv = b;
      if (s && a[w-1]) av = a - (longint'(1) << w);
      if (s && b[w-1]) bv = b - (longint'(1) << w);
      want = (av * bv) & ((longint'(1) << (2 * w)) - 1);
      @(negedge clk);
      set_in(w, a, b, s, 1'b1);
      t = 0;
      while (!get_in_ready(w) && t < 20) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk);
      @(negedge clk);
      set_in(w, longint'($urandom), longint'($urandom), ~s, 1'b0);
      lat = 0;
      while (!get_out_valid(w) && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      if (!get_out_valid(w)) lat = -1;
      checks++; if (lat !== w) begin errors++; $display("FAIL rand%0d_latency op %0d got %0d want %0d", w, i, lat, w); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      got = get_ans(w);
      checks++; if (got !== want) begin errors++; $display("FAIL rand%0d_ans op %0d a=%h b=%h s=%b got %h want %h", w, i, a, b, s, got, want); end
      set_out_ready(w, 1'b1);
      @(negedge clk);
      set_out_ready(w, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus6.in_valid = 1'b0; bus6.A = '0; bus6.B = '0; bus6.is_signed = 1'b0; bus6.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.is_signed = 1'b0; bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.A = '0; bus16.B = '0; bus16.is_signed = 1'b0; bus16.out_ready = 1'b0;

    test_reset();
    test_directed("umax", 6'd63, 6'd63, 1'b0, 12'hF81);
    test_directed("smin", 6'h20, 6'h20, 1'b1, 12'h400);
    test_directed("sneg", 6'h3F, 6'd5, 1'b1, 12'hFFB);
    test_directed("zero", 6'd0, 6'd63, 1'b0, 12'h000);
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random(8, 1000);
    test_random(16, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
